// File: rtl/seq_arith_if.sv
// Handshake bundle between a requester and the seq_arith divider/multiplier engines.
// Defining SEQ_ARITH_DBZ_EN adds the div_dbz completion flag.
interface seq_arith_if #(parameter int WIDTH = 32);
  logic             div_en;
  logic [WIDTH-1:0] div_y;
  logic [WIDTH-1:0] div_x;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_done;
`ifdef SEQ_ARITH_DBZ_EN
  logic             div_dbz;
`endif
  logic             mul_enable;
  logic [WIDTH-1:0] mul_multiplicand;
  logic [WIDTH-1:0] mul_multiplier;
  logic [WIDTH-1:0] mul_result;
  logic             mul_done;

`ifdef SEQ_ARITH_DBZ_EN
  modport master (output div_en, div_y, div_x, mul_enable, mul_multiplicand, mul_multiplier,
                  input  div_q, div_r, div_done, div_dbz, mul_result, mul_done);
  modport slave  (input  div_en, div_y, div_x, mul_enable, mul_multiplicand, mul_multiplier,
                  output div_q, div_r, div_done, div_dbz, mul_result, mul_done);
`else
  modport master (output div_en, div_y, div_x, mul_enable, mul_multiplicand, mul_multiplier,
                  input  div_q, div_r, div_done, mul_result, mul_done);
  modport slave  (input  div_en, div_y, div_x, mul_enable, mul_multiplicand, mul_multiplier,
                  output div_q, div_r, div_done, mul_result, mul_done);
`endif
endinterface

// File: rtl/seq_arith.sv
// Iterative restoring divider and shift-add multiplier, one result bit per clock each.
// SEQ_ARITH_DBZ_EN adds div_dbz and a short-cut completion for a zero divisor.
module seq_arith #(
  parameter int WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  seq_arith_if.slave arith
);
  localparam int CW = $clog2(WIDTH + 1);

  // D_IDLE: wait for div_en | D_RUN: one restoring step/cycle | D_FIN: publish q/r, pulse done
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_FIN} div_state_t;
  // M_IDLE: wait for enable | M_RUN: shift-add steps, then publish | M_DONE: hold done until enable drops
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mul_state_t;

  div_state_t       dst_q, dst_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] divq_q, divq_d;
  logic [WIDTH-1:0] divr_q, divr_d;
  logic [CW-1:0]    dcnt_q, dcnt_d;
  logic             ddone_q, ddone_d;
  logic [WIDTH:0]   trial, diff;
`ifdef SEQ_ARITH_DBZ_EN
  logic             dbz_q, dbz_d;
  logic             dbzo_q, dbzo_d;
`endif

  mul_state_t       mst_q, mst_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mres_q, mres_d;
  logic [CW-1:0]    mcnt_q, mcnt_d;
  logic             mdone_q, mdone_d;

  // The dividend register doubles as the quotient: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    dst_d   = dst_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    divq_d  = divq_q;
    divr_d  = divr_q;
    dcnt_d  = dcnt_q;
    ddone_d = 1'b0;
`ifdef SEQ_ARITH_DBZ_EN
    dbz_d   = dbz_q;
    dbzo_d  = 1'b0;
`endif
    trial   = {rem_q, dvd_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    case (dst_q)
      D_IDLE: begin
        if (arith.div_en) begin
          dvd_d  = arith.div_y;
          dvs_d  = arith.div_x;
          rem_d  = '0;
          dcnt_d = CW'(WIDTH);
          dst_d  = D_RUN;
`ifdef SEQ_ARITH_DBZ_EN
          dbz_d  = (arith.div_x == '0);
          if (arith.div_x == '0) begin
            dvd_d = '1;
            rem_d = arith.div_y;
            dst_d = D_FIN;
          end
`endif
        end
      end
      D_RUN: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        dcnt_d = dcnt_q - CW'(1);
        if (dcnt_q == CW'(1)) dst_d = D_FIN;
      end
      D_FIN: begin
        divq_d  = dvd_q;
        divr_d  = rem_q;
        ddone_d = 1'b1;
`ifdef SEQ_ARITH_DBZ_EN
        dbzo_d  = dbz_q;
`endif
        dst_d   = D_IDLE;
      end
      default: dst_d = D_IDLE;
    endcase
  end

  // The counter reaching zero while still in M_RUN is the publish cycle.
  always_comb begin
    mst_d   = mst_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    mres_d  = mres_q;
    mcnt_d  = mcnt_q;
    mdone_d = mdone_q;
    case (mst_q)
      M_IDLE: begin
        if (arith.mul_enable) begin
          ma_d   = arith.mul_multiplicand;
          mb_d   = arith.mul_multiplier;
          acc_d  = '0;
          mcnt_d = CW'(WIDTH);
          mst_d  = M_RUN;
        end
      end
      M_RUN: begin
        if (!arith.mul_enable) begin
          mst_d = M_IDLE;
        end else if (mcnt_q == '0) begin
          mres_d  = acc_q;
          mdone_d = 1'b1;
          mst_d   = M_DONE;
        end else begin
          if (mb_q[0]) acc_d = acc_q + ma_q;
          ma_d   = {ma_q[WIDTH-2:0], 1'b0};
          mb_d   = {1'b0, mb_q[WIDTH-1:1]};
          mcnt_d = mcnt_q - CW'(1);
        end
      end
      M_DONE: begin
        if (!arith.mul_enable) begin
          mdone_d = 1'b0;
          mst_d   = M_IDLE;
        end
      end
      default: mst_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dst_q   <= D_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      divq_q  <= '0;
      divr_q  <= '0;
      dcnt_q  <= '0;
      ddone_q <= 1'b0;
`ifdef SEQ_ARITH_DBZ_EN
      dbz_q   <= 1'b0;
      dbzo_q  <= 1'b0;
`endif
      mst_q   <= M_IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      mres_q  <= '0;
      mcnt_q  <= '0;
      mdone_q <= 1'b0;
    end else begin
      dst_q   <= dst_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      divq_q  <= divq_d;
      divr_q  <= divr_d;
      dcnt_q  <= dcnt_d;
      ddone_q <= ddone_d;
`ifdef SEQ_ARITH_DBZ_EN
      dbz_q   <= dbz_d;
      dbzo_q  <= dbzo_d;
`endif
      mst_q   <= mst_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      mres_q  <= mres_d;
      mcnt_q  <= mcnt_d;
      mdone_q <= mdone_d;
    end
  end

  assign arith.div_q      = divq_q;
  assign arith.div_r      = divr_q;
  assign arith.div_done   = ddone_q;
`ifdef SEQ_ARITH_DBZ_EN
  assign arith.div_dbz    = dbzo_q;
`endif
  assign arith.mul_result = mres_q;
  assign arith.mul_done   = mdone_q;
endmodule

// File: tb/tb_seq_arith.sv
// Directed bench for seq_arith: queued expected results are checked as each engine completes.
module tb_seq_arith;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_arith_if #(.WIDTH(W)) arith ();
  seq_arith #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .arith(arith));

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } div_exp_t;

  div_exp_t     div_sb[$];
  logic [W-1:0] mul_sb[$];
  int nvec  = 0;
  int nfail = 0;
  logic div_done_prev = 1'b0;
  logic mul_done_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    div_exp_t     e;
    logic [W-1:0] m;
    if (!rst) begin
      if (div_done_prev) chk("div_done_pulse", 64'(arith.div_done), 64'd0);
      if (arith.div_done) begin
        chk("div_sb_nonempty", 64'(div_sb.size() != 0), 64'd1);
        if (div_sb.size() != 0) begin
          e = div_sb.pop_front();
          chk("div_q", 64'(arith.div_q), 64'(e.q));
          chk("div_r", 64'(arith.div_r), 64'(e.r));
`ifdef SEQ_ARITH_DBZ_EN
          chk("div_dbz", 64'(arith.div_dbz), 64'(e.dbz));
`endif
        end
      end
      if (arith.mul_done && !mul_done_prev) begin
        chk("mul_sb_nonempty", 64'(mul_sb.size() != 0), 64'd1);
        if (mul_sb.size() != 0) begin
          m = mul_sb.pop_front();
          chk("mul_result", 64'(arith.mul_result), 64'(m));
        end
      end
    end
    div_done_prev <= arith.div_done;
    mul_done_prev <= arith.mul_done;
  end

  task automatic div_start(input logic [W-1:0] y, input logic [W-1:0] x);
    div_exp_t e;
    arith.div_en = 1'b1;
    arith.div_y  = y;
    arith.div_x  = x;
    e.q   = (x == '0) ? '1 : y / x;
    e.r   = (x == '0) ? y : y % x;
    e.dbz = (x == '0);
    div_sb.push_back(e);
  endtask

  // Latency counts edges after the one that samples the request.
  task automatic div_wait(input int exp_lat);
    int lat = 0;
    @(posedge clk);
    #1 arith.div_en = 1'b0;
    forever begin
      @(negedge clk);
      if (arith.div_done || lat > 80) break;
      @(posedge clk);
      lat++;
    end
    chk("div_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic mul_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic push);
    logic [W-1:0] p;
    arith.mul_enable       = 1'b1;
    arith.mul_multiplicand = a;
    arith.mul_multiplier   = b;
    p = a * b;
    if (push) mul_sb.push_back(p);
  endtask

  task automatic mul_wait(input int exp_lat);
    int lat = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (arith.mul_done || lat > 80) break;
      @(posedge clk);
      lat++;
    end
    chk("mul_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic mul_release();
    repeat (2) begin
      @(negedge clk);
      chk("mul_done_hold", 64'(arith.mul_done), 64'd1);
    end
    arith.mul_enable = 1'b0;
    @(negedge clk);
    chk("mul_done_fall", 64'(arith.mul_done), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_div_q"}, 64'(arith.div_q), 64'd0);
    chk({tag, "_div_r"}, 64'(arith.div_r), 64'd0);
    chk({tag, "_div_done"}, 64'(arith.div_done), 64'd0);
    chk({tag, "_mul_result"}, 64'(arith.mul_result), 64'd0);
    chk({tag, "_mul_done"}, 64'(arith.mul_done), 64'd0);
`ifdef SEQ_ARITH_DBZ_EN
    chk({tag, "_div_dbz"}, 64'(arith.div_dbz), 64'd0);
`endif
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic seen_div, seen_mul;
    rst                    = 1'b1;
    arith.div_en           = 1'b0;
    arith.div_y            = '0;
    arith.div_x            = '0;
    arith.mul_enable       = 1'b0;
    arith.mul_multiplicand = '0;
    arith.mul_multiplier   = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    div_start(32'd2147483647, 32'd16807);
    div_wait(W + 1);

    div_start(32'd5, 32'd127773);
    div_wait(W + 1);
    div_start(32'hFFFF_FFFF, 32'd1);
    div_wait(W + 1);

    @(negedge clk);
    div_start(32'd7, 32'd0);
`ifdef SEQ_ARITH_DBZ_EN
    div_wait(1);
`else
    div_wait(W + 1);
`endif

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = $urandom;
      b = ($urandom >> $urandom_range(0, 28)) | 32'd1;
      div_start(a, b);
      div_wait(W + 1);
    end

    @(negedge clk);
    mul_start(32'd16807, 32'd5, 1'b1);
    mul_wait(W + 1);
    mul_release();
    mul_start(32'd0, 32'd2836, 1'b1);
    mul_wait(W + 1);
    mul_release();

    @(negedge clk);
    mul_start(32'h0001_0000, 32'h0001_0001, 1'b1);
    mul_wait(W + 1);
    mul_release();

    @(negedge clk);
    mul_start(32'd7, 32'd9, 1'b0);
    repeat (10) @(negedge clk);
    arith.mul_enable = 1'b0;
    seen_mul = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (arith.mul_done) seen_mul = 1'b1;
    end
    chk("mul_abort_no_done", 64'(seen_mul), 64'd0);
    chk("mul_abort_result_hold", 64'(arith.mul_result), 64'h0001_0000);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mul_start($urandom, $urandom, 1'b1);
      mul_wait(W + 1);
      mul_release();
    end

    @(negedge clk);
    div_start(32'd2147483647, 32'd16807);
    mul_start(32'd16807, 32'd5, 1'b1);
    @(posedge clk);
    #1 arith.div_en = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_midop");
    div_sb.delete();
    mul_sb.delete();
    arith.mul_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_div = 1'b0;
    seen_mul = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (arith.div_done) seen_div = 1'b1;
      if (arith.mul_done) seen_mul = 1'b1;
    end
    chk("rst_no_div_done", 64'(seen_div), 64'd0);
    chk("rst_no_mul_done", 64'(seen_mul), 64'd0);

    div_start(32'd2147483647, 32'd16807);
    div_wait(W + 1);
    repeat (3) @(negedge clk);
    chk("div_sb_drained", 64'(div_sb.size()), 64'd0);
    chk("mul_sb_drained", 64'(mul_sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
